// File: rtl/spart_pkg.sv
// Shared definitions for the SPART receive/transmit buffering blocks.
// Holds the character width and the capture-FSM state encoding.
package spart_pkg;

    localparam int SPART_DATA_W = 8;

    typedef enum logic {
        CAP_WAIT = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_e;

endpackage

// File: rtl/spart_fifo_ram.sv
// Register-array storage for the SPART FIFOs.
// Synchronous write port, asynchronous read port.
module spart_fifo_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/spart_rx_fifo.sv
// Receive-side FIFO behind the SPART receiver: captures each rda byte once,
// acknowledges it with clear_rda, and offers a first-word-fall-through read port.
module spart_rx_fifo
    import spart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = SPART_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rda,
    input  logic [DATA_W-1:0]     rx_data,
    output logic                  clear_rda,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  state_dbg
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    cap_state_e              state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    clear_rda_q, clear_rda_d;

    logic                    empty_w;
    logic                    full_w;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    drop;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_COUNT);

    // Receiver handshake: rda is a level held until clear_rda is seen; the byte
    // is taken in the WAIT cycle where rda=1, and clear_rda stays high (ACK)
    // until rda falls, so one rda assertion yields exactly one capture.
    always_comb begin
        state_d = state_q;
        wr_fire = 1'b0;
        drop    = 1'b0;
        case (state_q)
            CAP_WAIT: begin
                if (rda) begin
                    // A pop in the same cycle frees the slot being written.
                    if (!full_w || rd_en) begin
                        wr_fire = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    state_d = CAP_ACK;
                end
            end
            CAP_ACK: begin
                if (!rda) begin
                    state_d = CAP_WAIT;
                end
            end
            default: begin
                state_d = CAP_WAIT;
            end
        endcase
    end

    always_comb begin
        rd_fire     = rd_en && !empty_w;
        clear_rda_d = (state_d == CAP_ACK);

        wr_ptr_d = wr_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CAP_WAIT;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            clear_rda_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            clear_rda_q <= clear_rda_d;
        end
    end

    spart_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

    assign clear_rda = clear_rda_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: directed scenarios plus randomized receiver/consumer
// traffic, checked against a queue-based reference of the buffer's contents.
module tb_spart_rx_fifo;

  localparam int DL    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rda;
  logic [DW-1:0] rx_data;
  logic          clear_rda;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          overflow;
  logic          clr_overflow;
  logic          state_dbg;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int  m_count = 0;
  bit  m_ack   = 1'b0;
  bit  m_ovf   = 1'b0;
  bit  mon_en  = 1'b0;

  spart_rx_fifo #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rda          (rda),
    .rx_data      (rx_data),
    .clear_rda    (clear_rda),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: contents as a queue of bytes, occupancy as an integer
  always @(posedge clk) begin : model
    bit rd_ok;
    bit wr_ok;
    bit dropped;
    if (rst) begin
      exp_q.delete();
      m_count = 0;
      m_ack   = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      rd_ok   = rd_en && (m_count > 0);
      wr_ok   = 1'b0;
      dropped = 1'b0;
      if (!m_ack && rda) begin
        if (m_count < DEPTH || rd_en) begin
          wr_ok = 1'b1;
          exp_q.push_back(rx_data);
        end else begin
          dropped = 1'b1;
        end
        m_ack = 1'b1;
      end else if (m_ack && !rda) begin
        m_ack = 1'b0;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      m_count = m_count + int'(wr_ok) - int'(rd_ok);
    end
  end

  // monitor: pops the scoreboard whenever a read is presented on a non-empty FIFO
  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (mon_en) begin
      if (rd_en && m_count > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_underflow: got 0x%0h expected no read", dout);
        end else begin
          e = exp_q.pop_front();
          check("dout", dout, e);
        end
      end
      check("count", count, m_count);
      check("empty", empty, m_count == 0);
      check("full", full, m_count == DEPTH);
      check("overflow", overflow, m_ovf);
      check("clear_rda", clear_rda, m_ack);
      check("state_dbg", state_dbg, m_ack);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input int hold, input bit with_rd);
    int n;
    rda     = 1'b1;
    rx_data = b;
    rd_en   = with_rd;
    tick();
    rd_en = 1'b0;
    n = 0;
    while (!clear_rda && n < 8) begin
      tick();
      n++;
    end
    if (!clear_rda) begin
      checks++;
      errors++;
      $display("FAIL clear_rda_wait: got 0 expected 1 within 8 cycles");
    end
    repeat (hold) tick();
    rda = 1'b0;
    tick();
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    rda          = 1'b0;
    rx_data      = '0;
    rd_en        = 1'b0;
    clr_overflow = 1'b0;
    tick();
    mon_en = 1'b1;
    check("reset_empty", empty, 1'b1);
    check("reset_count", count, 0);
    check("reset_clear_rda", clear_rda, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // single byte, latency of one cycle to dout and clear_rda
    rda     = 1'b1;
    rx_data = 8'hA5;
    tick();
    check("single_dout", dout, 8'hA5);
    check("single_empty", empty, 1'b0);
    check("single_clear", clear_rda, 1'b1);
    rda = 1'b0;
    tick();
    check("single_count", count, 1);
    check("single_back_wait", clear_rda, 1'b0);
    pop_n(1);
    check("single_drained", empty, 1'b1);

    // long ACK: one capture regardless of how long rda stays high
    send_byte(8'h3C, 20, 1'b0);
    check("long_ack_count", count, 1);
    pop_n(1);

    // fill then overflow
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    check("fill_full", full, 1'b1);
    check("fill_count", count, DEPTH);
    check("fill_overflow", overflow, 1'b1);
    check("fill_head", dout, 8'h00);
    pop_n(DEPTH);
    check("drain_empty", empty, 1'b1);
    check("overflow_sticky", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("overflow_cleared", overflow, 1'b0);

    // wrap-around
    for (int i = 0; i < 10; i++) send_byte(8'h30 + 8'(i), 0, 1'b0);
    pop_n(10);
    for (int i = 0; i < 12; i++) send_byte(8'h80 + 8'(i), 0, 1'b0);
    check("wrap_count", count, 12);
    pop_n(12);
    check("wrap_empty", empty, 1'b1);

    // full + write + read in the same cycle
    for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i), 0, 1'b0);
    send_byte(8'h5A, 0, 1'b1);
    check("full_rw_count", count, DEPTH);
    check("full_rw_overflow", overflow, 1'b0);
    pop_n(DEPTH - 1);
    check("full_rw_last", dout, 8'h5A);
    pop_n(1);

    // empty + write + read in the same cycle
    send_byte(8'h77, 0, 1'b1);
    check("empty_rw_count", count, 1);
    check("empty_rw_dout", dout, 8'h77);
    pop_n(1);

    // reset mid-operation with data stored and the FSM in ACK
    for (int i = 0; i < 5; i++) send_byte(8'hD0 + 8'(i), 0, 1'b0);
    rda     = 1'b1;
    rx_data = 8'hC3;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_empty", empty, 1'b1);
    check("midrst_count", count, 0);
    check("midrst_clear", clear_rda, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    rst = 1'b0;
    rda = 1'b0;
    tick();
    check("midrst_no_ack", clear_rda, 1'b0);
    send_byte(8'h96, 0, 1'b0);
    check("midrst_recapture", dout, 8'h96);
    check("midrst_recount", count, 1);
    pop_n(1);

    // randomized receiver and consumer traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!rda && !clear_rda && $urandom_range(0, 2) == 0) begin
        rda     = 1'b1;
        rx_data = 8'($urandom);
      end else if (rda && clear_rda && $urandom_range(0, 2) == 0) begin
        rda = 1'b0;
      end
      if (cyc < 1000) rd_en = ($urandom_range(0, 4) == 0);
      else            rd_en = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 31) == 0);
      tick();
    end
    clr_overflow = 1'b0;
    rd_en        = 1'b0;
    rda          = 1'b0;
    repeat (3) tick();
    pop_n(DEPTH + 2);
    check("final_empty", empty, 1'b1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
